mips_memsys: RTL and testbench

- Unified byte-wide program/data memory for the multicycle MIPS core, with a streaming program loader and a small memory-mapped I/O window.
- After reset it holds the core in reset and accepts a program byte stream through a valid/ready handshake, writing it from address 0 upward.
- It then releases the core and serves the core's memread/memwrite traffic.
- A store to HALT_ADR stops the core again.

---
 rtl/mips_memsys.sv | 204 ++++++++++++++++++++
 tb/tb_mips_memsys.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_memsys.sv
// Unified byte-wide program/data memory for the multicycle MIPS core with streaming loader and I/O window.
// Define MEMSYS_CHECKSUM_EN to treat the load_last byte as a mod-256 checksum of the stream.
module mips_memsys #(
    parameter int               WIDTH      = 8,
    parameter int               ADRBITS    = 8,
    parameter logic [WIDTH-1:0] IO_OUT_ADR = 8'hFF,
    parameter logic [WIDTH-1:0] HALT_ADR   = 8'hFE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             cpu_reset,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             memread,
    input  logic             memwrite,
    output logic [WIDTH-1:0] memdata,
    output logic [WIDTH-1:0] out_port,
    output logic             out_strobe,
    output logic             halted,
    output logic             load_ovf,
    output logic             err
);

    localparam int DEPTH = 1 << ADRBITS;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT, S_ERROR} state_t;

    state_t             state_q, state_d;
    logic [ADRBITS-1:0] ptr_q, ptr_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic [WIDTH-1:0]   out_port_q, out_port_d;
    logic               out_strobe_q, out_strobe_d;
    logic               halted_q, halted_d;
    logic               load_ovf_q, load_ovf_d;
`ifdef MEMSYS_CHECKSUM_EN
    logic               err_q, err_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
`endif

    logic [WIDTH-1:0]   mem [DEPTH];
    logic               mem_we;
    logic [ADRBITS-1:0] mem_wa;
    logic [WIDTH-1:0]   mem_wd;

    logic [ADRBITS-1:0] adr_idx;
    logic               load_fire;
    logic               ptr_full;

    assign adr_idx    = adr[ADRBITS-1:0];
    assign load_ready = (state_q == S_LOAD) & ~restart;
    assign load_fire  = load_valid & load_ready;
    assign ptr_full   = &ptr_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cpu_reset_d  = cpu_reset_q;
        out_port_d   = out_port_q;
        out_strobe_d = 1'b0;
        halted_d     = halted_q;
        load_ovf_d   = load_ovf_q;
        mem_we       = 1'b0;
        mem_wa       = adr_idx;
        mem_wd       = writedata;
`ifdef MEMSYS_CHECKSUM_EN
        err_d        = err_q;
        sum_d        = sum_q;
`endif
        if (restart) begin
            state_d     = S_LOAD;
            ptr_d       = '0;
            cpu_reset_d = 1'b1;
            halted_d    = 1'b0;
            load_ovf_d  = 1'b0;
`ifdef MEMSYS_CHECKSUM_EN
            err_d       = 1'b0;
            sum_d       = '0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_fire) begin
`ifdef MEMSYS_CHECKSUM_EN
                        if (load_last) begin
                            if (load_data == sum_q) begin
                                state_d     = S_RUN;
                                cpu_reset_d = 1'b0;
                            end else begin
                                state_d = S_ERROR;
                                err_d   = 1'b1;
                            end
                        end else begin
                            mem_we = 1'b1;
                            mem_wa = ptr_q;
                            mem_wd = load_data;
                            sum_d  = sum_q + load_data;
                            if (ptr_full) begin
                                state_d    = S_ERROR;
                                err_d      = 1'b1;
                                load_ovf_d = 1'b1;
                            end else begin
                                ptr_d = ptr_q + 1'b1;
                            end
                        end
`else
                        mem_we = 1'b1;
                        mem_wa = ptr_q;
                        mem_wd = load_data;
                        // A byte landing in the top word ends the stream even without load_last.
                        if (load_last || ptr_full) begin
                            state_d     = S_RUN;
                            cpu_reset_d = 1'b0;
                        end
                        if (ptr_full && !load_last) begin
                            load_ovf_d = 1'b1;
                        end
                        if (!ptr_full) begin
                            ptr_d = ptr_q + 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    if (memwrite) begin
                        if (adr == IO_OUT_ADR) begin
                            out_port_d   = writedata;
                            out_strobe_d = 1'b1;
                        end else if (adr == HALT_ADR) begin
                            state_d     = S_HALT;
                            cpu_reset_d = 1'b1;
                            halted_d    = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            ptr_q        <= '0;
            cpu_reset_q  <= 1'b1;
            out_port_q   <= '0;
            out_strobe_q <= 1'b0;
            halted_q     <= 1'b0;
            load_ovf_q   <= 1'b0;
`ifdef MEMSYS_CHECKSUM_EN
            err_q        <= 1'b0;
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cpu_reset_q  <= cpu_reset_d;
            out_port_q   <= out_port_d;
            out_strobe_q <= out_strobe_d;
            halted_q     <= halted_d;
            load_ovf_q   <= load_ovf_d;
`ifdef MEMSYS_CHECKSUM_EN
            err_q        <= err_d;
            sum_q        <= sum_d;
`endif
        end
    end

    // RAM contents survive reset so a partially loaded image stays visible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        memdata = '0;
        if (memread && !cpu_reset_q) begin
            if (adr == IO_OUT_ADR) begin
                memdata = out_port_q;
            end else begin
                memdata = mem[adr_idx];
            end
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign out_port   = out_port_q;
    assign out_strobe = out_strobe_q;
    assign halted     = halted_q;
    assign load_ovf   = load_ovf_q;
`ifdef MEMSYS_CHECKSUM_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mips_memsys.sv
// Self-checking bench for mips_memsys (default build): expected read data is queued as stimulus is driven.
module tb_mips_memsys;

    logic       clk = 1'b0;
    logic       reset;
    logic       restart;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_last;
    logic       cpu_reset;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       memread;
    logic       memwrite;
    logic [7:0] memdata;
    logic [7:0] out_port;
    logic       out_strobe;
    logic       halted;
    logic       load_ovf;
    logic       err;

    mips_memsys #(
        .WIDTH(8),
        .ADRBITS(8),
        .IO_OUT_ADR(8'hFF),
        .HALT_ADR(8'hFE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .restart(restart),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data(load_data),
        .load_last(load_last),
        .cpu_reset(cpu_reset),
        .adr(adr),
        .writedata(writedata),
        .memread(memread),
        .memwrite(memwrite),
        .memdata(memdata),
        .out_port(out_port),
        .out_strobe(out_strobe),
        .halted(halted),
        .load_ovf(load_ovf),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] data;
    } rd_t;

    rd_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [7:0] a, input logic [7:0] d);
        rd_t e;
        e.adr  = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        check_eq("load_ready_in_load", {31'b0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic drain_reads();
        rd_t e;
        while (sb.size() > 0) begin
            e       = sb.pop_front();
            adr     = e.adr;
            memread = 1'b1;
            #1;
            check_eq($sformatf("rd_%02h", e.adr), {24'b0, memdata}, {24'b0, e.data});
        end
        memread = 1'b0;
    endtask

    task automatic core_write(input logic [7:0] a, input logic [7:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        #1;
        check_eq("load_ready_during_restart", {31'b0, load_ready}, 32'd0);
        tick();
        restart = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] img[4];
        logic [7:0] d;
        img[0] = 8'h80; img[1] = 8'h02; img[2] = 8'h00; img[3] = 8'h10;

        reset = 1'b0; restart = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        adr = '0; writedata = '0; memread = 1'b0; memwrite = 1'b0;
        tick();
        check_eq("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check_eq("rst_load_ready", {31'b0, load_ready}, 32'd1);
        check_eq("rst_out_port", {24'b0, out_port}, 32'd0);
        check_eq("rst_out_strobe", {31'b0, out_strobe}, 32'd0);
        check_eq("rst_halted", {31'b0, halted}, 32'd0);
        check_eq("rst_load_ovf", {31'b0, load_ovf}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b1;
        tick();

        // Initial 4-byte program
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check_eq("cpu_reset_before_last", {31'b0, cpu_reset}, 32'd1);
            load_byte(img[i], (i == 3));
            push_rd(8'(i), img[i]);
        end
        check_eq("cpu_reset_after_last", {31'b0, cpu_reset}, 32'd0);
        check_eq("load_ready_in_run", {31'b0, load_ready}, 32'd0);
        check_eq("load_ovf_normal", {31'b0, load_ovf}, 32'd0);
        drain_reads();
        adr = 8'h00; memread = 1'b0; #1;
        check_eq("memdata_no_read", {24'b0, memdata}, 32'd0);

        // Ordinary RAM store and read-during-write
        core_write(8'h40, 8'h5A);
        push_rd(8'h40, 8'h5A);
        drain_reads();
        adr = 8'h40; writedata = 8'h77; memwrite = 1'b1; memread = 1'b1; #1;
        check_eq("rw_pre_write_data", {24'b0, memdata}, 32'h5A);
        tick();
        memwrite = 1'b0;
        #1;
        check_eq("rw_post_write_data", {24'b0, memdata}, 32'h77);
        memread = 1'b0;

        // Output port
        core_write(8'hFF, 8'h2A);
        check_eq("out_port_update", {24'b0, out_port}, 32'h2A);
        check_eq("out_strobe_high", {31'b0, out_strobe}, 32'd1);
        tick();
        check_eq("out_strobe_one_cycle", {31'b0, out_strobe}, 32'd0);
        push_rd(8'hFF, 8'h2A);
        drain_reads();

        // Halt, ignored stores, restart
        core_write(8'hFE, 8'h00);
        check_eq("halt_halted", {31'b0, halted}, 32'd1);
        check_eq("halt_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check_eq("halt_load_ready", {31'b0, load_ready}, 32'd0);
        adr = 8'h00; memread = 1'b1; #1;
        check_eq("memdata_in_cpu_reset", {24'b0, memdata}, 32'd0);
        memread = 1'b0;
        core_write(8'hFF, 8'h33);
        check_eq("halt_ignores_io_store", {24'b0, out_port}, 32'h2A);
        check_eq("halt_no_strobe", {31'b0, out_strobe}, 32'd0);
        pulse_restart();
        check_eq("restart_load_ready", {31'b0, load_ready}, 32'd1);
        check_eq("restart_halted", {31'b0, halted}, 32'd0);
        check_eq("restart_out_port_kept", {24'b0, out_port}, 32'h2A);
        check_eq("restart_cpu_reset", {31'b0, cpu_reset}, 32'd1);

        // Restart colliding with a valid byte at ptr=3
        load_byte(8'hA1, 1'b0);
        load_byte(8'hA2, 1'b0);
        load_byte(8'hA3, 1'b0);
        load_valid = 1'b1; load_data = 8'hEE;
        pulse_restart();
        load_valid = 1'b0;
        load_byte(8'hC3, 1'b1);
        push_rd(8'h00, 8'hC3);
        push_rd(8'h01, 8'hA2);
        push_rd(8'h02, 8'hA3);
        push_rd(8'h03, 8'h10);
        check_eq("short_load_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        drain_reads();

        // Full 256-byte stream without load_last
        core_write(8'hFE, 8'h00);
        pulse_restart();
        for (int i = 0; i < 256; i++) begin
            d = 8'(i) ^ 8'h5C;
            if (i == 255) begin
                check_eq("ovf_before_last_byte", {31'b0, load_ovf}, 32'd0);
                check_eq("cpu_reset_before_fill", {31'b0, cpu_reset}, 32'd1);
            end
            load_byte(d, 1'b0);
            push_rd(8'(i), (i == 255) ? 8'h2A : d);
        end
        check_eq("ovf_set", {31'b0, load_ovf}, 32'd1);
        check_eq("ovf_run_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        check_eq("ovf_load_ready", {31'b0, load_ready}, 32'd0);
        check_eq("ovf_halted", {31'b0, halted}, 32'd0);
        load_valid = 1'b1; load_data = 8'h00;
        repeat (3) tick();
        load_valid = 1'b0;
        drain_reads();

        // Asynchronous reset mid-run
        reset = 1'b0;
        #1;
        check_eq("midrun_rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check_eq("midrun_rst_load_ovf", {31'b0, load_ovf}, 32'd0);
        check_eq("midrun_rst_out_port", {24'b0, out_port}, 32'd0);
        check_eq("midrun_rst_load_ready", {31'b0, load_ready}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        load_byte(8'h99, 1'b1);
        push_rd(8'h00, 8'h99);
        push_rd(8'h01, 8'h5D);
        push_rd(8'hFF, 8'h00);
        drain_reads();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
